xor_cipher_seq_ctrl: RTL and testbench

Sequencer for the dual XOR cipher datapath. It loads an M-bit key serially into both the encrypt and decrypt cores, then runs one transaction per period: issue a plaintext byte, collect the ciphertext, decrypt it, and compare the result. The ciphertext goes to the UART transmitter through a valid/ready handshake. It sits between the key source/board top and the two cipher cores plus the UART tx in the FPGA wrapper.

---
 rtl/xor_cipher_pkg.sv | 16 +
 rtl/xor_period_timer.sv | 37 +++
 rtl/xor_cipher_seq_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_xor_cipher_seq_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_cipher_pkg.sv
// Shared types and constants for the XOR cipher sequencer and its period timer.
package xor_cipher_pkg;

    localparam int BYTE_W          = 8;
    localparam int DEFAULT_TIMEOUT = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_KEY  = 3'd1,
        ST_WAIT = 3'd2,
        ST_ENC  = 3'd3,
        ST_DEC  = 3'd4,
        ST_TX   = 3'd5
    } state_e;

endpackage

// File: rtl/xor_period_timer.sv
// Free-running period counter 0..PERIOD-1 with enable and synchronous clear.
module xor_period_timer #(
    parameter int PERIOD = 2000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] count_q, count_d;
    logic          at_end;

    assign at_end = (count_q == CW'(PERIOD - 1));
    assign tick   = en && at_end;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = at_end ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/xor_cipher_seq_ctrl.sv
// Sequencer: serial key load into both cipher cores, then one periodic
// encrypt/decrypt/compare transaction whose ciphertext is handed to UART tx.
module xor_cipher_seq_ctrl
    import xor_cipher_pkg::*;
#(
    parameter int M         = 32,
    parameter int TX_PERIOD = 2000,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [M-1:0]      key,
    input  logic              key_load,
    output logic              cfg_en,
    output logic              cfg_sdo,
    output logic [BYTE_W-1:0] enc_pt,
    output logic              enc_stb,
    input  logic [BYTE_W-1:0] enc_ct,
    input  logic              enc_vld,
    output logic [BYTE_W-1:0] dec_ct,
    output logic              dec_stb,
    input  logic [BYTE_W-1:0] dec_pt,
    input  logic              dec_vld,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [BYTE_W-1:0] err_cnt,
    output logic              overrun,
    output logic              busy
);

    localparam int BW = (M > 1) ? $clog2(M) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    function automatic logic [BYTE_W-1:0] sat_inc(input logic [BYTE_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    state_e            state_q, state_d;
    logic [M-1:0]      shadow_q, shadow_d;
    logic [M-1:0]      pend_key_q, pend_key_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              pend_q, pend_d;
    logic              running_q, running_d;
    logic [BYTE_W-1:0] pt_q, pt_d;
    logic [BYTE_W-1:0] ct_q, ct_d;
    logic [TW-1:0]     to_cnt_q, to_cnt_d;

    logic              cfg_en_q, cfg_en_d;
    logic              cfg_sdo_q, cfg_sdo_d;
    logic [BYTE_W-1:0] enc_pt_q, enc_pt_d;
    logic              enc_stb_q, enc_stb_d;
    logic [BYTE_W-1:0] dec_ct_q, dec_ct_d;
    logic              dec_stb_q, dec_stb_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic [BYTE_W-1:0] err_cnt_q, err_cnt_d;
    logic              overrun_q, overrun_d;
    logic              busy_q, busy_d;

    logic              tick;
    logic              tmr_clr;
    logic              start_key;
    logic [M-1:0]      start_val;
    logic              abandon;

    xor_period_timer #(
        .PERIOD (TX_PERIOD)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (running_q),
        .clr  (tmr_clr),
        .tick (tick)
    );

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        pend_key_d = pend_key_q;
        bit_cnt_d  = bit_cnt_q;
        pend_d     = pend_q;
        running_d  = running_q;
        pt_d       = pt_q;
        ct_d       = ct_q;
        to_cnt_d   = to_cnt_q;
        cfg_en_d   = cfg_en_q;
        cfg_sdo_d  = cfg_sdo_q;
        enc_pt_d   = enc_pt_q;
        enc_stb_d  = 1'b0;
        dec_ct_d   = dec_ct_q;
        dec_stb_d  = 1'b0;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        err_cnt_d  = err_cnt_q;
        overrun_d  = overrun_q;
        tmr_clr    = 1'b0;
        start_key  = 1'b0;
        start_val  = key;
        abandon    = 1'b0;

        // Requests that arrive mid-transaction wait for the next WAIT visit.
        if (key_load && (state_q != ST_IDLE) && (state_q != ST_WAIT)) begin
            pend_d     = 1'b1;
            pend_key_d = key;
        end
        if (tick && (state_q != ST_WAIT)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (key_load) begin
                    start_key = 1'b1;
                end
            end
            ST_KEY: begin
                if (bit_cnt_q == BW'(M - 1)) begin
                    cfg_en_d  = 1'b0;
                    cfg_sdo_d = 1'b0;
                    running_d = 1'b1;
                    tmr_clr   = 1'b1;
                    state_d   = ST_WAIT;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    shadow_d  = {shadow_q[0], shadow_q[M-1:1]};
                    cfg_sdo_d = shadow_q[1];
                end
            end
            ST_WAIT: begin
                if (key_load) begin
                    start_key = 1'b1;
                    pend_d    = 1'b0;
                end else if (pend_q) begin
                    start_key = 1'b1;
                    start_val = pend_key_q;
                    pend_d    = 1'b0;
                end else if (tick) begin
                    enc_pt_d  = pt_q;
                    enc_stb_d = 1'b1;
                    to_cnt_d  = '0;
                    state_d   = ST_ENC;
                end
            end
            ST_ENC: begin
                if (enc_vld) begin
                    ct_d      = enc_ct;
                    dec_ct_d  = enc_ct;
                    dec_stb_d = 1'b1;
                    to_cnt_d  = '0;
                    state_d   = ST_DEC;
                end else if (!enc_stb_q) begin
                    if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                        abandon = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end
            ST_DEC: begin
                if (dec_vld) begin
                    if (dec_pt != pt_q) begin
                        err_cnt_d = sat_inc(err_cnt_q);
                    end
                    tx_data_d  = ct_q;
                    tx_valid_d = 1'b1;
                    state_d    = ST_TX;
                end else if (!dec_stb_q) begin
                    if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                        abandon = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end
            ST_TX: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    pt_d       = pt_q + 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Re-keying stops the period timer so no tick can be dropped during KEY.
        if (start_key) begin
            shadow_d  = start_val;
            bit_cnt_d = '0;
            cfg_en_d  = 1'b1;
            cfg_sdo_d = start_val[0];
            running_d = 1'b0;
            state_d   = ST_KEY;
        end
        if (abandon) begin
            err_cnt_d = sat_inc(err_cnt_q);
            pt_d      = pt_q + 1'b1;
            state_d   = ST_WAIT;
        end

        busy_d = (state_d != ST_IDLE) && (state_d != ST_WAIT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            pend_q     <= 1'b0;
            running_q  <= 1'b0;
            pt_q       <= '0;
            to_cnt_q   <= '0;
            cfg_en_q   <= 1'b0;
            cfg_sdo_q  <= 1'b0;
            enc_pt_q   <= '0;
            enc_stb_q  <= 1'b0;
            dec_ct_q   <= '0;
            dec_stb_q  <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            err_cnt_q  <= '0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            pend_q     <= pend_d;
            running_q  <= running_d;
            pt_q       <= pt_d;
            to_cnt_q   <= to_cnt_d;
            cfg_en_q   <= cfg_en_d;
            cfg_sdo_q  <= cfg_sdo_d;
            enc_pt_q   <= enc_pt_d;
            enc_stb_q  <= enc_stb_d;
            dec_ct_q   <= dec_ct_d;
            dec_stb_q  <= dec_stb_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            err_cnt_q  <= err_cnt_d;
            overrun_q  <= overrun_d;
            busy_q     <= busy_d;
        end
        shadow_q   <= shadow_d;
        pend_key_q <= pend_key_d;
        ct_q       <= ct_d;
    end

    assign cfg_en   = cfg_en_q;
    assign cfg_sdo  = cfg_sdo_q;
    assign enc_pt   = enc_pt_q;
    assign enc_stb  = enc_stb_q;
    assign dec_ct   = dec_ct_q;
    assign dec_stb  = dec_stb_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign err_cnt  = err_cnt_q;
    assign overrun  = overrun_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_xor_cipher_seq_ctrl.sv
// Self-checking bench for xor_cipher_seq_ctrl with behavioural cipher cores and UART sink.
module tb_xor_cipher_seq_ctrl;

    localparam int M         = 32;
    localparam int TX_PERIOD = 50;
    localparam int TIMEOUT   = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [M-1:0] key;
    logic         key_load;
    logic         cfg_en, cfg_sdo;
    logic [7:0]   enc_pt;
    logic         enc_stb;
    logic [7:0]   enc_ct;
    logic         enc_vld;
    logic [7:0]   dec_ct;
    logic         dec_stb;
    logic [7:0]   dec_pt;
    logic         dec_vld;
    logic [7:0]   tx_data;
    logic         tx_valid, tx_ready;
    logic [7:0]   err_cnt;
    logic         overrun, busy;

    always #5 clk = ~clk;

    xor_cipher_seq_ctrl #(
        .M         (M),
        .TX_PERIOD (TX_PERIOD),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key      (key),
        .key_load (key_load),
        .cfg_en   (cfg_en),
        .cfg_sdo  (cfg_sdo),
        .enc_pt   (enc_pt),
        .enc_stb  (enc_stb),
        .enc_ct   (enc_ct),
        .enc_vld  (enc_vld),
        .dec_ct   (dec_ct),
        .dec_stb  (dec_stb),
        .dec_pt   (dec_pt),
        .dec_vld  (dec_vld),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .err_cnt  (err_cnt),
        .overrun  (overrun),
        .busy     (busy)
    );

    typedef struct {
        logic [M-1:0] key;
        logic [M-1:0] exp_stream;
        int           exp_len;
    } key_vec_t;

    typedef struct {
        logic [7:0] pt;
        int         offset;
        logic [7:0] exp_tx;
    } run_vec_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Behavioural cores: encrypt is pt^0x5A, decrypt is ct^0x5A, both answer 2 cycles after the strobe.
    bit         enc_on    = 1'b1;
    bit         dec_flip  = 1'b0;
    bit         rand_flip = 1'b0;
    int         enc_dly   = 0;
    int         dec_dly   = 0;
    logic [7:0] enc_hold, dec_hold;

    int         model_pt  = 0;
    int         model_err = 0;

    int           cfg_cnt = 0, cfg_first = 0, cfg_last = 0;
    logic [M-1:0] cfg_stream;
    int           launch_cnt = 0, last_launch = 0;
    logic [7:0]   last_launch_pt;
    int           launch_cyc[16];
    logic [7:0]   launch_pt[16];
    int           tx_cnt = 0, last_tx_cyc = 0;
    int           tx_cyc_a[16];
    logic [7:0]   tx_dat[16];
    int           dec_stb_cnt = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic monitor();
        if (cfg_en === 1'b1) begin
            if (cfg_cnt == 0) cfg_first = cyc;
            if (cfg_cnt < M) cfg_stream[cfg_cnt] = cfg_sdo;
            cfg_cnt++;
            cfg_last = cyc;
        end
        if (enc_stb === 1'b1) begin
            launch_cyc[launch_cnt % 16] = cyc;
            launch_pt[launch_cnt % 16]  = enc_pt;
            last_launch    = cyc;
            last_launch_pt = enc_pt;
            launch_cnt++;
        end
        if (dec_stb === 1'b1) dec_stb_cnt++;
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            tx_cyc_a[tx_cnt % 16] = cyc;
            tx_dat[tx_cnt % 16]   = tx_data;
            last_tx_cyc = cyc;
            tx_cnt++;
            check("tx_data_vs_model", 64'(tx_data), 64'(8'(model_pt) ^ 8'h5A));
            model_pt = (model_pt + 1) % 256;
        end
    endtask

    task automatic cores();
        bit flip;
        enc_vld = 1'b0;
        dec_vld = 1'b0;
        if (enc_dly > 0) begin
            enc_dly--;
            if (enc_dly == 0) begin
                enc_vld = 1'b1;
                enc_ct  = enc_hold;
            end
        end
        if (dec_dly > 0) begin
            dec_dly--;
            if (dec_dly == 0) begin
                dec_vld = 1'b1;
                dec_pt  = dec_hold;
            end
        end
        if (enc_stb === 1'b1) begin
            if (enc_on) begin
                enc_dly  = 2;
                enc_hold = enc_pt ^ 8'h5A;
            end else begin
                model_pt  = (model_pt + 1) % 256;
                model_err = model_err + 1;
            end
        end
        if (dec_stb === 1'b1) begin
            flip     = dec_flip || (rand_flip && ($urandom_range(0, 1) == 1));
            dec_dly  = 2;
            dec_hold = dec_ct ^ 8'h5A ^ (flip ? 8'h01 : 8'h00);
            if (flip) model_err = model_err + 1;
        end
    endtask

    task automatic step();
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        cores();
    endtask

    task automatic clear_models();
        enc_dly   = 0;
        dec_dly   = 0;
        enc_vld   = 1'b0;
        dec_vld   = 1'b0;
        model_pt  = 0;
        model_err = 0;
    endtask

    key_vec_t kv[4];
    run_vec_t rv[3];

    initial begin
        int k, w, s, t, base, exp_err;

        kv[0] = '{32'hA5A55A5A, 32'hA5A55A5A, 32};
        kv[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32};
        kv[2] = '{32'h00000001, 32'h00000001, 32};
        kv[3] = '{32'h80000000, 32'h80000000, 32};
        rv[0] = '{8'h00, 1 * TX_PERIOD, 8'h5A};
        rv[1] = '{8'h01, 2 * TX_PERIOD, 8'h5B};
        rv[2] = '{8'h02, 3 * TX_PERIOD, 8'h58};

        rst      = 1'b0;
        key      = '0;
        key_load = 1'b0;
        tx_ready = 1'b1;
        enc_ct   = '0;
        dec_pt   = '0;
        clear_models();
        repeat (3) step();
        clear_models();

        check("rst_cfg_en",   64'(cfg_en),   64'(0));
        check("rst_cfg_sdo",  64'(cfg_sdo),  64'(0));
        check("rst_enc_pt",   64'(enc_pt),   64'(0));
        check("rst_enc_stb",  64'(enc_stb),  64'(0));
        check("rst_dec_ct",   64'(dec_ct),   64'(0));
        check("rst_dec_stb",  64'(dec_stb),  64'(0));
        check("rst_tx_data",  64'(tx_data),  64'(0));
        check("rst_tx_valid", 64'(tx_valid), 64'(0));
        check("rst_err_cnt",  64'(err_cnt),  64'(0));
        check("rst_overrun",  64'(overrun),  64'(0));
        check("rst_busy",     64'(busy),     64'(0));
        rst = 1'b1;
        repeat (3) step();

        // Key loads: first from IDLE, the rest from WAIT before the first tick.
        for (int i = 0; i < 4; i++) begin
            cfg_cnt  = 0;
            key      = kv[i].key;
            key_load = 1'b1;
            k        = cyc;
            step();
            key_load = 1'b0;
            key      = M'($urandom);
            check("key_busy", 64'(busy), 64'(1));
            repeat (M + 5) step();
            check("key_len",    64'(cfg_cnt),    64'(kv[i].exp_len));
            check("key_first",  64'(cfg_first),  64'(k + 1));
            check("key_last",   64'(cfg_last),   64'(k + M));
            check("key_stream", 64'(cfg_stream), 64'(kv[i].exp_stream));
            check("key_idle",   64'(busy),       64'(0));
        end

        // Normal run from WAIT entry.
        w          = cfg_last + 1;
        launch_cnt = 0;
        tx_cnt     = 0;
        for (int n = 0; n < 4 * TX_PERIOD && tx_cnt < 3; n++) step();
        check("run_tx_count", 64'(tx_cnt), 64'(3));
        for (int i = 0; i < 3; i++) begin
            check("run_launch_cyc", 64'(launch_cyc[i]), 64'(w + rv[i].offset));
            check("run_launch_pt",  64'(launch_pt[i]),  64'(rv[i].pt));
            check("run_tx_data",    64'(tx_dat[i]),     64'(rv[i].exp_tx));
            check("run_tx_latency", 64'(tx_cyc_a[i]),   64'(launch_cyc[i] + 6));
        end
        check("run_err_cnt", 64'(err_cnt), 64'(0));

        // Decrypt mismatch: ciphertext unchanged, error count rises per transaction.
        dec_flip = 1'b1;
        tx_cnt   = 0;
        for (int n = 0; n < 3 * TX_PERIOD && tx_cnt < 1; n++) step();
        check("mm_err_1", 64'(err_cnt), 64'(1));
        for (int n = 0; n < 3 * TX_PERIOD && tx_cnt < 2; n++) step();
        dec_flip = 1'b0;
        check("mm_tx_count", 64'(tx_cnt),    64'(2));
        check("mm_tx_0",     64'(tx_dat[0]), 64'(8'h59));
        check("mm_tx_1",     64'(tx_dat[1]), 64'(8'h5E));
        check("mm_err_2",    64'(err_cnt),   64'(2));
        check("mm_overrun",  64'(overrun),   64'(0));

        // Overrun: UART stalls across a tick.
        tx_ready = 1'b0;
        for (int n = 0; n < 3 * TX_PERIOD && tx_valid !== 1'b1; n++) step();
        check("ovr_tx_valid_seen", 64'(tx_valid), 64'(1));
        launch_cnt = 0;
        repeat (TX_PERIOD + 10) step();
        check("ovr_overrun",  64'(overrun),    64'(1));
        check("ovr_held",     64'(tx_valid),   64'(1));
        check("ovr_held_dat", 64'(tx_data),    64'(8'h5F));
        check("ovr_no_launch",64'(launch_cnt), 64'(0));
        tx_ready = 1'b1;
        tx_cnt   = 0;
        repeat (5) step();
        check("ovr_one_xfer", 64'(tx_cnt),   64'(1));
        check("ovr_released", 64'(tx_valid), 64'(0));

        // Reset in the middle of a key shift.
        key      = 32'hDEADBEEF;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        repeat (9) step();
        check("rk_shifting", 64'(cfg_en), 64'(1));
        rst = 1'b0;
        step();
        clear_models();
        check("rk_cfg_en", 64'(cfg_en),  64'(0));
        check("rk_busy",   64'(busy),    64'(0));
        check("rk_ovr",    64'(overrun), 64'(0));
        check("rk_err",    64'(err_cnt), 64'(0));
        rst        = 1'b1;
        launch_cnt = 0;
        cfg_cnt    = 0;
        repeat (2 * TX_PERIOD + 10) step();
        check("rk_no_launch", 64'(launch_cnt), 64'(0));
        check("rk_no_cfg",    64'(cfg_cnt),    64'(0));

        // Encrypt core silent: abandonment after TIMEOUT cycles.
        enc_on      = 1'b0;
        key         = 32'h0F0F1234;
        key_load    = 1'b1;
        step();
        key_load    = 1'b0;
        launch_cnt  = 0;
        dec_stb_cnt = 0;
        for (int n = 0; n < M + 3 * TX_PERIOD && launch_cnt < 1; n++) step();
        check("to_launch", 64'(launch_cnt), 64'(1));
        s = last_launch;
        while (cyc < s + TIMEOUT) step();
        check("to_err_before", 64'(err_cnt), 64'(0));
        check("to_busy_before",64'(busy),    64'(1));
        step();
        check("to_err_after",  64'(err_cnt),     64'(1));
        check("to_busy_after", 64'(busy),        64'(0));
        check("to_no_dec_stb", 64'(dec_stb_cnt), 64'(0));
        enc_on = 1'b1;
        for (int n = 0; n < 3 * TX_PERIOD && launch_cnt < 2; n++) step();
        check("to_next_pt", 64'(last_launch_pt), 64'(1));

        // key_load during ENC is held pending and serviced right after TX.
        key      = 32'h1234ABCD;
        key_load = 1'b1;
        cfg_cnt  = 0;
        base     = tx_cnt;
        step();
        key_load = 1'b0;
        key      = M'($urandom);
        check("pend_no_cfg", 64'(cfg_en), 64'(0));
        for (int n = 0; n < 60 && tx_cnt < base + 1; n++) step();
        check("pend_tx", 64'(tx_cnt), 64'(base + 1));
        t = last_tx_cyc;
        repeat (M + 5) step();
        check("pend_first",  64'(cfg_first),  64'(t + 2));
        check("pend_len",    64'(cfg_cnt),    64'(M));
        check("pend_stream", 64'(cfg_stream), 64'(32'h1234ABCD));
        check("pend_err",    64'(err_cnt),    64'(1));

        // Random backpressure and random decrypt corruption against the model.
        rand_flip = 1'b1;
        base      = tx_cnt;
        for (int n = 0; n < 30 * TX_PERIOD && tx_cnt < base + 20; n++) begin
            tx_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        tx_ready  = 1'b1;
        rand_flip = 1'b0;
        repeat (20) step();
        exp_err = (model_err > 255) ? 255 : model_err;
        check("rnd_tx_count", 64'(tx_cnt >= base + 20), 64'(1));
        check("rnd_err_cnt",  64'(err_cnt), 64'(exp_err));
        check("rnd_overrun",  64'(overrun), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
